// File: rtl/priority_code_decoder_3x8_seq.sv
// Buffers 3-bit codes in a small FIFO and replays each one as a one-hot 8-bit strobe
// held PULSE_LEN cycles, separated by GAP_LEN idle cycles.
module priority_code_decoder_3x8_seq #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PULSE_LEN = 2,
    parameter int unsigned GAP_LEN   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [2:0]               code_in,
    input  logic                     code_valid,
    output logic                     code_ready,
    output logic [7:0]               out,
    output logic                     out_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W      = $clog2(DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam int unsigned HOLD_MAX   = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int unsigned HOLD_W     = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam int unsigned PULSE_LOAD = PULSE_LEN - 1;
    localparam int unsigned GAP_LOAD   = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [2:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        out_q, out_d;
    logic              push_c;
    logic              pop_c;
    logic [7:0]        head_onehot_c;

    // Ready depends only on reset and registered occupancy, never on a same-cycle pop.
    assign code_ready    = !rst && (count_q < CNT_W'(DEPTH));
    assign push_c        = code_valid && code_ready;
    assign head_onehot_c = 8'b1 << mem_q[rd_ptr_q];

    // Replay sequencer: IDLE -> DRIVE -> (GAP) -> next strobe or IDLE; en=1 aborts to IDLE.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        out_d   = out_q;
        pop_c   = 1'b0;
        if (en) begin
            state_d = IDLE;
            hold_d  = '0;
            out_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        pop_c   = 1'b1;
                        out_d   = head_onehot_c;
                        state_d = DRIVE;
                        hold_d  = HOLD_W'(PULSE_LOAD);
                    end
                end
                DRIVE: begin
                    if (hold_q != '0) begin
                        hold_d = hold_q - HOLD_W'(1);
                    end else if (GAP_LEN > 0) begin
                        out_d   = '0;
                        state_d = GAP;
                        hold_d  = HOLD_W'(GAP_LOAD);
                    end else if (count_q != '0) begin
                        pop_c  = 1'b1;
                        out_d  = head_onehot_c;
                        hold_d = HOLD_W'(PULSE_LOAD);
                    end else begin
                        out_d   = '0;
                        state_d = IDLE;
                    end
                end
                GAP: begin
                    // Chain straight into the next strobe so the idle stretch is exactly GAP_LEN.
                    if (hold_q != '0) begin
                        hold_d = hold_q - HOLD_W'(1);
                    end else if (count_q != '0) begin
                        pop_c   = 1'b1;
                        out_d   = head_onehot_c;
                        state_d = DRIVE;
                        hold_d  = HOLD_W'(PULSE_LOAD);
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    hold_d  = '0;
                    out_d   = '0;
                end
            endcase
        end
    end

    // FIFO pointer and occupancy update.
    always_comb begin
        wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            out_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            out_q    <= out_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= code_in;
        end
    end

    assign out        = out_q;
    assign out_valid  = (state_q == DRIVE);
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign fifo_count = count_q;

endmodule

// File: tb/tb_priority_code_decoder_3x8_seq.sv
// Bench for priority_code_decoder_3x8_seq: directed table, corner sequences and
// randomized traffic against a window-based reference model (GAP_LEN=1 and GAP_LEN=0 instances).
module tb_priority_code_decoder_3x8_seq;

    localparam int DEPTH = 4;
    localparam int PULSE = 2;

    logic       clk = 1'b0;
    logic       rst, en, code_valid;
    logic [2:0] code_in;
    logic       ready_a, ready_b;
    logic [7:0] out_a, out_b;
    logic       ov_a, ov_b, busy_a, busy_b;
    logic [2:0] cnt_a, cnt_b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    priority_code_decoder_3x8_seq #(.DEPTH(4), .PULSE_LEN(2), .GAP_LEN(1)) dut (
        .clk(clk), .rst(rst), .en(en), .code_in(code_in), .code_valid(code_valid),
        .code_ready(ready_a), .out(out_a), .out_valid(ov_a), .busy(busy_a), .fifo_count(cnt_a));

    priority_code_decoder_3x8_seq #(.DEPTH(4), .PULSE_LEN(2), .GAP_LEN(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .code_in(code_in), .code_valid(code_valid),
        .code_ready(ready_b), .out(out_b), .out_valid(ov_b), .busy(busy_b), .fifo_count(cnt_b));

    always #5 clk = ~clk;

    // Model: each popped code owns a window of PULSE+gap cycles; strobe is lit for the first PULSE.
    int mbuf [2][DEPTH];
    int mhead[2];
    int mcnt [2];
    int left [2];
    int cur  [2];
    int gapv [2] = '{1, 0};

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    endtask

    function automatic int m_out(input int i);
        logic [7:0] one;
        one = 8'd1;
        return (left[i] > gapv[i]) ? int'(one << cur[i]) : 0;
    endfunction

    task automatic model_step();
        bit push_ok;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mcnt[i] = 0; mhead[i] = 0; left[i] = 0;
            end else begin
                push_ok = code_valid && (mcnt[i] < DEPTH);
                if (en) begin
                    left[i] = 0;
                end else if (left[i] > 1) begin
                    left[i]--;
                end else if (mcnt[i] > 0) begin
                    cur[i]   = mbuf[i][mhead[i]];
                    mhead[i] = (mhead[i] + 1) % DEPTH;
                    mcnt[i]--;
                    left[i]  = PULSE + gapv[i];
                end else begin
                    left[i] = 0;
                end
                if (push_ok) begin
                    mbuf[i][(mhead[i] + mcnt[i]) % DEPTH] = int'(code_in);
                    mcnt[i]++;
                end
            end
        end
    endtask

    task automatic check_model();
        int eo;
        eo = m_out(0);
        chk("a_out", int'(out_a), eo);
        chk("a_out_valid", int'(ov_a), int'(eo != 0));
        chk("a_busy", int'(busy_a), int'(left[0] > 0 || mcnt[0] > 0));
        chk("a_fifo_count", int'(cnt_a), mcnt[0]);
        chk("a_code_ready", int'(ready_a), int'(!rst && mcnt[0] < DEPTH));
        eo = m_out(1);
        chk("b_out", int'(out_b), eo);
        chk("b_out_valid", int'(ov_b), int'(eo != 0));
        chk("b_busy", int'(busy_b), int'(left[1] > 0 || mcnt[1] > 0));
        chk("b_fifo_count", int'(cnt_b), mcnt[1]);
        chk("b_code_ready", int'(ready_b), int'(!rst && mcnt[1] < DEPTH));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic drive(input logic r, input logic e, input logic v, input logic [2:0] c);
        rst = r; en = e; code_valid = v; code_in = c;
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic       valid;
        logic [2:0] code;
        logic [7:0] exp_out;
        int         exp_cnt;
        logic       exp_busy;
        logic       exp_ready;
    } vec_t;

    vec_t vecs[17];
    logic [7:0] seen[$];
    logic [7:0] prev;

    function automatic vec_t mk(input logic r, input logic e, input logic v, input logic [2:0] c,
                                input logic [7:0] o, input int n, input logic b, input logic rd);
        vec_t t;
        t.rst = r; t.en = e; t.valid = v; t.code = c;
        t.exp_out = o; t.exp_cnt = n; t.exp_busy = b; t.exp_ready = rd;
        return t;
    endfunction

    initial begin
        // Single code 5, then 7,0,3 back-to-back (GAP_LEN=1 instance).
        vecs[0]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 0);
        vecs[1]  = mk(0, 0, 1, 5, 8'h00, 1, 1, 1);
        vecs[2]  = mk(0, 0, 0, 0, 8'h20, 0, 1, 1);
        vecs[3]  = mk(0, 0, 0, 0, 8'h20, 0, 1, 1);
        vecs[4]  = mk(0, 0, 0, 0, 8'h00, 0, 1, 1);
        vecs[5]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 1);
        vecs[6]  = mk(0, 0, 1, 7, 8'h00, 1, 1, 1);
        vecs[7]  = mk(0, 0, 1, 0, 8'h80, 1, 1, 1);
        vecs[8]  = mk(0, 0, 1, 3, 8'h80, 2, 1, 1);
        vecs[9]  = mk(0, 0, 0, 0, 8'h00, 2, 1, 1);
        vecs[10] = mk(0, 0, 0, 0, 8'h01, 1, 1, 1);
        vecs[11] = mk(0, 0, 0, 0, 8'h01, 1, 1, 1);
        vecs[12] = mk(0, 0, 0, 0, 8'h00, 1, 1, 1);
        vecs[13] = mk(0, 0, 0, 0, 8'h08, 0, 1, 1);
        vecs[14] = mk(0, 0, 0, 0, 8'h08, 0, 1, 1);
        vecs[15] = mk(0, 0, 0, 0, 8'h00, 0, 1, 1);
        vecs[16] = mk(0, 0, 0, 0, 8'h00, 0, 0, 1);

        drive(1, 0, 0, 0);
        tick();
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].valid, vecs[i].code);
            tick();
            chk($sformatf("vec%0d_out", i), int'(out_a), int'(vecs[i].exp_out));
            chk($sformatf("vec%0d_cnt", i), int'(cnt_a), vecs[i].exp_cnt);
            chk($sformatf("vec%0d_busy", i), int'(busy_a), int'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_ready", i), int'(ready_a), int'(vecs[i].exp_ready));
        end

        // Fill with en=1, overflow attempt, then replay order.
        drive(0, 1, 1, 2); tick();
        drive(0, 1, 1, 6); tick();
        drive(0, 1, 1, 1); tick();
        drive(0, 1, 1, 4); tick();
        chk("full_cnt", int'(cnt_a), 4);
        chk("full_ready", int'(ready_a), 0);
        drive(0, 1, 1, 7); tick();
        chk("overflow_cnt", int'(cnt_a), 4);
        drive(0, 0, 0, 0);
        prev = 8'h00;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (out_a != 8'h00 && out_a != prev) seen.push_back(out_a);
            prev = out_a;
        end
        chk("replay_n", seen.size(), 4);
        if (seen.size() == 4) begin
            chk("replay0", int'(seen[0]), 'h04);
            chk("replay1", int'(seen[1]), 'h40);
            chk("replay2", int'(seen[2]), 'h02);
            chk("replay3", int'(seen[3]), 'h10);
        end

        // Abort mid-DRIVE of code 2; queued 3 plays after en returns.
        drive(0, 0, 1, 2); tick();
        drive(0, 0, 1, 3); tick();
        chk("abort_pre", int'(out_a), 'h04);
        drive(0, 1, 0, 0); tick();
        chk("abort_out", int'(out_a), 0);
        chk("abort_cnt", int'(cnt_a), 1);
        drive(0, 0, 0, 0); tick();
        chk("resume_out", int'(out_a), 'h08);
        for (int i = 0; i < 5; i++) tick();

        // Reset during DRIVE with 3 codes queued.
        for (int i = 0; i < 4; i++) begin drive(0, 1, 1, 3'(i + 1)); tick(); end
        drive(0, 0, 0, 0); tick();
        chk("prerst_out", int'(out_a), 'h02);
        chk("prerst_cnt", int'(cnt_a), 3);
        drive(1, 0, 0, 0); tick();
        chk("rst_out", int'(out_a), 0);
        chk("rst_cnt", int'(cnt_a), 0);
        chk("rst_ready", int'(ready_a), 0);
        chk("rst_busy", int'(busy_a), 0);

        // GAP_LEN=0 instance: 1 then 6 with no idle cycle between.
        drive(0, 0, 1, 1); tick();
        drive(0, 0, 1, 6); tick();
        chk("g0_s0", int'(out_b), 'h02);
        drive(0, 0, 0, 0); tick();
        chk("g0_s1", int'(out_b), 'h02);
        tick();
        chk("g0_s2", int'(out_b), 'h40);
        tick();
        chk("g0_s3", int'(out_b), 'h40);
        tick();
        chk("g0_s4", int'(out_b), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)));
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
